// File: rtl/tinker_mem_responder.sv
// Byte-addressed memory responder with fixed access latency.
// One outstanding request; little-endian, unaligned 4/8-byte accesses.
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_size,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW     = $clog2(MEM_BYTES);
    localparam logic [32:0] LIMIT  = 33'(MEM_BYTES);
    localparam bit          LAT0   = (LATENCY == 0);
    localparam logic [3:0]  LAT_LD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;

    logic        we_q;
    logic        size_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        accept;
    logic        go_resp;
    logic        op_we;
    logic        op_size;
    logic [31:0] op_addr;
    logic [63:0] op_wdata;
    logic [32:0] span;
    logic        in_range;
    logic        mem_we;
    logic [63:0] rd_data;
    logic [63:0] rdata_d;
    logic        err_d;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // In IDLE the live request is the operand (LATENCY=0 completes at accept).
    always_comb begin
        accept   = req_valid && req_ready_q;
        op_we    = we_q;
        op_size  = size_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_we    = req_we;
            op_size  = req_size;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
        go_resp = (state_q == IDLE && accept && LAT0)
               || (state_q == WAIT && cnt_q == 4'd0);
        span     = {1'b0, op_addr} + (op_size ? 33'd8 : 33'd4);
        in_range = (span <= LIMIT);
        mem_we   = reset && go_resp && op_we && in_range;
        err_d    = !in_range;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (op_size || k < 4) begin
                rd_data[8*k +: 8] = mem[op_addr[AW-1:0] + AW'(k)];
            end
        end
        rdata_d = (in_range && !op_we) ? rd_data : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (op_size || k < 4) begin
                    mem[op_addr[AW-1:0] + AW'(k)] <= op_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 64'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        size_q      <= req_size;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        if (LAT0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= rdata_d;
                            resp_err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_LD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata_d;
                        resp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 64'd0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboard bench for tinker_mem_responder (LATENCY=2 main instance,
// plus a small LATENCY=0 instance for single-cycle timing).
module tb_tinker_mem_responder;

    localparam int unsigned MB  = 524288;
    localparam int unsigned LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid0, req_ready0, req_we0, req_size0;
    logic [31:0] req_addr0;
    logic [63:0] req_wdata0;
    logic        resp_valid0, resp_ready0, resp_err0;
    logic [63:0] resp_rdata0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    tinker_mem_responder #(.MEM_BYTES(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_size(req_size0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Monitor: latency, stall stability, and data on each handshake.
    logic        prev_v = 1'b0;
    logic [63:0] hold_rd;
    logic        hold_err;
    always @(negedge clk) begin
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if (resp_valid && !prev_v) begin
                hold_rd  = resp_rdata;
                hold_err = resp_err;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp got=%h", resp_rdata);
                end else if (cyc - exp_q[0].acc != LAT) begin
                    errors++;
                    $display("FAIL latency got=%0d want=%0d",
                             cyc - exp_q[0].acc, LAT);
                end
            end else if (resp_valid) begin
                checks++;
                if (resp_rdata !== hold_rd || resp_err !== hold_err
                    || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_stable got=%h/%b/%b want=%h/%b/0",
                             resp_rdata, resp_err, req_ready,
                             hold_rd, hold_err);
                end
            end
            if (resp_valid && resp_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (resp_rdata !== e.rd || resp_err !== e.err) begin
                    errors++;
                    $display("FAIL resp got=%h err=%b want=%h err=%b",
                             resp_rdata, resp_err, e.rd, e.err);
                end
            end
            prev_v = resp_valid;
        end
    end

    task automatic issue(input bit we, input bit sz,
                         input logic [31:0] a, input logic [63:0] wd,
                         input logic [63:0] er, input bit ee,
                         input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout addr=%h", a);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        if (push) exp_q.push_back('{er, ee, cyc});
        req_valid = 1'b0;
    endtask

    task automatic issue0(input bit we, input bit sz,
                          input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] er, input bit ee);
        @(negedge clk);
        checks++;
        if (req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL lat0_ready got=%b want=1", req_ready0);
        end
        req_valid0 = 1'b1;
        req_we0    = we;
        req_size0  = sz;
        req_addr0  = a;
        req_wdata0 = wd;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid0 !== 1'b1 || resp_rdata0 !== er || resp_err0 !== ee) begin
            errors++;
            $display("FAIL lat0_resp got=%b/%h/%b want=1/%h/%b",
                     resp_valid0, resp_rdata0, resp_err0, er, ee);
        end
        req_valid0 = 1'b0;
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 1'b0;
        req_addr0 = '0; req_wdata0 = '0; resp_ready0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0
            || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h/%b want=1/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b1;

        issue(1, 1, 32'h100, 64'h1122334455667788, 64'd0, 0, 1);
        issue(0, 1, 32'h100, 64'd0, 64'h1122334455667788, 0, 1);
        issue(0, 0, 32'h100, 64'd0, 64'h0000000055667788, 0, 1);
        issue(1, 0, 32'h7FFFC, 64'hFFFF0000A5A5A5A5, 64'd0, 0, 1);
        issue(0, 1, 32'h7FFFC, 64'd0, 64'd0, 1, 1);
        issue(0, 0, 32'h7FFFC, 64'd0, 64'h00000000A5A5A5A5, 0, 1);
        issue(1, 1, 32'hFFFFFFFC, 64'hDEADBEEFDEADBEEF, 64'd0, 1, 1);
        issue(0, 0, 32'h7FFFC, 64'd0, 64'h00000000A5A5A5A5, 0, 1);
        issue(1, 1, 32'h103, 64'h0807060504030201, 64'd0, 0, 1);
        issue(0, 1, 32'h103, 64'd0, 64'h0807060504030201, 0, 1);
        issue(0, 0, 32'h105, 64'd0, 64'h0000000006050403, 0, 1);
        issue(0, 1, 32'h100, 64'd0, 64'h0504030201667788, 0, 1);
        issue(0, 0, 32'h107, 64'd0, 64'h0000000008070605, 0, 1);
        issue(1, 1, 32'h300, 64'd0, 64'd0, 0, 1);
        issue(1, 0, 32'h300, 64'hFFFFFFFFCAFEBABE, 64'd0, 0, 1);
        issue(0, 1, 32'h300, 64'd0, 64'h00000000CAFEBABE, 0, 1);
        drain();

        // Hold the response for five cycles, then release.
        resp_ready = 1'b0;
        issue(0, 0, 32'h100, 64'd0, 64'h0000000001667788, 0, 1);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle got=%b/%b want=1/0",
                     req_ready, resp_valid);
        end
        drain();

        // Abort a store by resetting while it waits.
        issue(1, 1, 32'h200, 64'hAAAAAAAABBBBBBBB, 64'd0, 0, 1);
        drain();
        issue(1, 1, 32'h200, 64'h1234567812345678, 64'd0, 0, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0
            || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%b/%b/%h/%b want=1/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(0, 1, 32'h200, 64'd0, 64'hAAAAAAAABBBBBBBB, 0, 1);
        drain();

        issue0(1, 0, 32'd60, 64'h0000000012345678, 64'd0, 0);
        issue0(0, 0, 32'd60, 64'd0, 64'h0000000012345678, 0);
        issue0(0, 1, 32'd60, 64'd0, 64'd0, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
